gpr_snapshot_seq: RTL and testbench

//  Sequences a full GPR snapshot for difftest on every instruction commit.
//  - Uses the register file's spare read port; the core always has priority on that port.
//  - Reads registers one at a time and assembles a flat vector.
//  - Presents {pc, gprs} to the DPI register-export block over a valid/ready handshake.
//  - Sits between the commit stage, the register file and the difftest DPI layer.

---
 rtl/difftest_pkg.sv | 18 +
 rtl/gpr_snapshot_seq.sv | 170 +++++++++++++++++
 tb/tb_gpr_snapshot_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/difftest_pkg.sv
// Shared types and sizing helpers for the difftest register-snapshot path.
package difftest_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2
  } snap_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int OVERRUN_W = 16;

  // Width of a GPR index; kept at least 1 so degenerate sizes still elaborate.
  function automatic int GPR_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpr_snapshot_seq.sv
// Walks the register file through its spare read port after each commit and
// hands {pc, gprs} to the difftest export layer over valid/ready.
module gpr_snapshot_seq
  import difftest_pkg::*;
#(
  parameter int NUM_GPRS = 32,
  parameter int XLEN     = XLEN_DEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          commit_valid,
  input  logic [XLEN-1:0]               commit_pc,
  input  logic                          core_rd_req,
  output logic                          rf_ren,
  output logic [$clog2(NUM_GPRS)-1:0]   rf_raddr,
  input  logic [XLEN-1:0]               rf_rdata,
  output logic                          snap_valid,
  input  logic                          snap_ready,
  output logic [XLEN-1:0]               snap_pc,
  output logic [NUM_GPRS*XLEN-1:0]      snap_gprs,
  output logic                          busy,
  output logic [OVERRUN_W-1:0]          overrun_cnt
);

  localparam int                IDX_W    = GPR_IDX_W(NUM_GPRS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_GPRS - 1);
  localparam logic [IDX_W-1:0]  FIRST_IDX = IDX_W'(1);

  snap_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   issue_done_q, issue_done_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic                   pending_q, pending_d;
  logic [XLEN-1:0]        pend_pc_q, pend_pc_d;
  logic [OVERRUN_W-1:0]   overrun_q, overrun_d;
  logic                   inflight_v_q, inflight_v_d;
  logic [IDX_W-1:0]       inflight_addr_q, inflight_addr_d;
  logic                   gpr_we;
  logic                   handshake;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    issue_done_d    = issue_done_q;
    pc_d            = pc_q;
    pending_d       = pending_q;
    pend_pc_d       = pend_pc_q;
    overrun_d       = overrun_q;
    inflight_v_d    = 1'b0;
    inflight_addr_d = inflight_addr_q;
    rf_ren          = 1'b0;
    rf_raddr        = '0;
    snap_valid      = 1'b0;
    gpr_we          = 1'b0;
    handshake       = 1'b0;

    case (state_q)
      IDLE: begin
        if (commit_valid) begin
          pc_d         = commit_pc;
          idx_d        = FIRST_IDX;
          issue_done_d = 1'b0;
          state_d      = SCAN;
        end
      end

      SCAN: begin
        rf_raddr = idx_q;
        // The core owns the port whenever it asks; the scan just waits.
        if (!issue_done_q && !core_rd_req) begin
          rf_ren          = 1'b1;
          inflight_v_d    = 1'b1;
          inflight_addr_d = idx_q;
          if (idx_q == LAST_IDX) begin
            issue_done_d = 1'b1;
          end else begin
            idx_d = idx_q + FIRST_IDX;
          end
        end
        // Returning data lands regardless of this cycle's port owner.
        gpr_we = inflight_v_q;
        if (issue_done_q && inflight_v_q) begin
          state_d = PRESENT;
        end
      end

      PRESENT: begin
        snap_valid = 1'b1;
        if (snap_ready) begin
          handshake = 1'b1;
          if (pending_q || commit_valid) begin
            pc_d         = commit_valid ? commit_pc : pend_pc_q;
            pending_d    = 1'b0;
            idx_d        = FIRST_IDX;
            issue_done_d = 1'b0;
            state_d      = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Commits that arrive while a snapshot is in progress are coalesced.
    if (commit_valid && (state_q != IDLE)) begin
      if (pending_q && (overrun_q != {OVERRUN_W{1'b1}})) begin
        overrun_d = overrun_q + OVERRUN_W'(1);
      end
      if (!handshake) begin
        pending_d = 1'b1;
        pend_pc_d = commit_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      issue_done_q    <= 1'b0;
      pc_q            <= '0;
      pending_q       <= 1'b0;
      pend_pc_q       <= '0;
      overrun_q       <= '0;
      inflight_v_q    <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      issue_done_q    <= issue_done_d;
      pc_q            <= pc_d;
      pending_q       <= pending_d;
      pend_pc_q       <= pend_pc_d;
      overrun_q       <= overrun_d;
      inflight_v_q    <= inflight_v_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  // x0 is hardwired: its slice has no storage at all.
  assign snap_gprs[XLEN-1:0] = '0;

  for (genvar gi = 1; gi < NUM_GPRS; gi++) begin : g_slice
    logic [XLEN-1:0] gpr_q, gpr_d;

    always_comb begin
      gpr_d = gpr_q;
      if (gpr_we && (inflight_addr_q == IDX_W'(gi))) begin
        gpr_d = rf_rdata;
      end
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        gpr_q <= '0;
      end else begin
        gpr_q <= gpr_d;
      end
    end

    assign snap_gprs[XLEN*gi +: XLEN] = gpr_q;
  end

  assign snap_pc     = pc_q;
  assign busy        = (state_q != IDLE) | pending_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_gpr_snapshot_seq.sv
// Directed-plus-random bench for gpr_snapshot_seq with a register-file model
// and a cycle-level expectation model of the snapshot protocol.
module tb_gpr_snapshot_seq;

  localparam int NG = 32;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            commit_valid = 1'b0;
  logic [XL-1:0]   commit_pc = '0;
  logic            core_rd_req = 1'b0;
  logic            rf_ren;
  logic [4:0]      rf_raddr;
  logic [XL-1:0]   rf_rdata = '0;
  logic            snap_valid;
  logic            snap_ready = 1'b0;
  logic [XL-1:0]   snap_pc;
  logic [NG*XL-1:0] snap_gprs;
  logic            busy;
  logic [15:0]     overrun_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [XL-1:0] regs [NG];
  int            t0;
  logic [XL-1:0] exp_pc;
  logic [XL-1:0] pend_pc;
  bit            pend;
  logic [15:0]   exp_ov;
  bit            nxt;

  gpr_snapshot_seq #(.NUM_GPRS(NG), .XLEN(XL)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .core_rd_req  (core_rd_req),
    .rf_ren       (rf_ren),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .snap_valid   (snap_valid),
    .snap_ready   (snap_ready),
    .snap_pc      (snap_pc),
    .snap_gprs    (snap_gprs),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: data one cycle after the request, garbage otherwise.
  always @(posedge clk) rf_rdata <= rf_ren ? regs[rf_raddr] : $urandom;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_gprs(input bit zero);
    for (int i = 0; i < NG; i++) begin
      logic [XL-1:0] e;
      e = (zero || i == 0) ? '0 : regs[i];
      check($sformatf("gpr%0d", i), 64'(snap_gprs[i*XL +: XL]), 64'(e));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rf_ren"}, rf_ren, 0);
    check({tag, "_rf_raddr"}, rf_raddr, 0);
    check({tag, "_snap_valid"}, snap_valid, 0);
    check({tag, "_snap_pc"}, snap_pc, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun_cnt, 0);
    check_gprs(1'b1);
  endtask

  task automatic load_regs(input bit random_fill);
    for (int i = 0; i < NG; i++) begin
      regs[i] = random_fill ? $urandom : (32'hA000_0000 + 32'(i));
    end
  endtask

  task automatic commit_idle(input logic [XL-1:0] pc);
    @(negedge clk);
    commit_valid = 1'b1;
    commit_pc    = pc;
    core_rd_req  = 1'b0;
    snap_ready   = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_snap_valid", snap_valid, 0);
    check("idle_rf_ren", rf_ren, 0);
    t0     = cyc;
    exp_pc = pc;
  endtask

  // Follows one snapshot from the cycle after its start to the handshake.
  // mode: 0 no contention, 1 five-cycle stall mid-scan, 2 random contention.
  task automatic follow(input int mode, input int ready_delay, input int n_extra,
                        input bit commit_hs, output bit next);
    int n = 0;
    int last_issue = -100;
    int pres = 0;
    bit exp_sv, hs, exp_ren, extra;
    logic [XL-1:0] cpc;
    hs   = 1'b0;
    next = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      exp_sv = (n == NG-1) && (cyc >= last_issue + 2);
      if (exp_sv) pres++;
      hs = exp_sv && (pres > ready_delay);
      case (mode)
        1:       core_rd_req = (cyc >= t0 + 10) && (cyc <= t0 + 14);
        2:       core_rd_req = ($urandom_range(0, 3) == 0);
        default: core_rd_req = 1'b0;
      endcase
      extra = !exp_sv && ((n_extra >= 1 && cyc == t0 + 3) || (n_extra >= 2 && cyc == t0 + 7));
      cpc          = $urandom;
      commit_valid = extra || (hs && commit_hs);
      commit_pc    = cpc;
      snap_ready   = hs;
      #1;
      exp_ren = (n < NG-1) && !core_rd_req;
      check("rf_ren", rf_ren, exp_ren);
      if (exp_ren) begin
        check("rf_raddr", rf_raddr, n + 1);
        n++;
        last_issue = cyc;
      end
      check("snap_valid", snap_valid, exp_sv);
      check("busy", busy, 1);
      if (exp_sv) begin
        check("snap_pc", snap_pc, exp_pc);
        check("overrun", overrun_cnt, exp_ov);
        check_gprs(1'b0);
      end
      if (commit_valid) begin
        if (pend && exp_ov != 16'hFFFF) exp_ov++;
        pend    = 1'b1;
        pend_pc = cpc;
      end
      if (hs) break;
    end
    check("handshake_reached", hs, 1);
    $display("snapshot pc=%h t0=%0d end=%0d mode=%0d delay=%0d extra=%0d hs_commit=%0d",
             exp_pc, t0, cyc, mode, ready_delay, n_extra, commit_hs);
    if (pend) begin
      exp_pc = pend_pc;
      pend   = 1'b0;
      t0     = cyc;
      next   = 1'b1;
    end else begin
      @(negedge clk);
      commit_valid = 1'b0;
      snap_ready   = 1'b0;
      core_rd_req  = 1'b0;
      #1;
      check("post_hs_snap_valid", snap_valid, 0);
      check("post_hs_busy", busy, 0);
      check("post_hs_rf_ren", rf_ren, 0);
    end
  endtask

  initial begin
    pend   = 1'b0;
    exp_ov = '0;
    load_regs(1'b0);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Uncontended scan with the A000_0000+i pattern.
    commit_idle(32'h8000_0000);
    follow(0, 0, 0, 1'b0, nxt);

    // Five-cycle core stall in the middle of the scan.
    commit_idle(32'h8000_0004);
    follow(1, 0, 0, 1'b0, nxt);

    // Consumer back-pressure for ten cycles.
    commit_idle(32'h8000_0008);
    follow(0, 10, 0, 1'b0, nxt);

    // Three commits coalesce; the second snapshot carries the last pc.
    load_regs(1'b1);
    commit_idle(32'h8000_1000);
    follow(0, 2, 2, 1'b0, nxt);
    check("coalesce_next", nxt, 1);
    if (nxt) follow(0, 0, 0, 1'b0, nxt);

    // Commit coincident with the handshake chains straight into a scan.
    commit_idle(32'h8000_2000);
    follow(0, 1, 0, 1'b1, nxt);
    check("hs_commit_next", nxt, 1);
    if (nxt) follow(2, 0, 0, 1'b0, nxt);

    // Reset in the middle of the scan.
    load_regs(1'b1);
    commit_idle(32'h8000_3000);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      commit_valid = 1'b0;
      core_rd_req  = 1'b0;
      #1;
      if (cyc == t0 + 17) begin
        check("raddr_at_reset", rf_raddr, 17);
        resetn = 1'b0;
        break;
      end
    end
    @(negedge clk);
    #1;
    check_zero_outputs("midscan_reset");
    pend   = 1'b0;
    exp_ov = '0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("after_reset_snap_valid", snap_valid, 0);
      check("after_reset_busy", busy, 0);
    end
    commit_idle(32'h8000_4000);
    follow(0, 0, 0, 1'b0, nxt);

    // Randomised snapshots with contention, back-pressure and coalescing.
    for (int r = 0; r < 6; r++) begin
      load_regs(1'b1);
      commit_idle($urandom);
      nxt = 1'b1;
      for (int s = 0; s < 4 && nxt; s++) begin
        follow(2, $urandom_range(0, 5), (s < 2) ? $urandom_range(0, 2) : 0,
               (s < 2) ? 1'($urandom_range(0, 1)) : 1'b0, nxt);
      end
      check("random_chain_done", nxt, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
